// File: rtl/port_alloc.sv
// Output-port allocator for one flit of a bufferless deflection router stage.
// Grants one productive (or deflection) port and forwards the remaining free ports.
module port_alloc #(
    parameter int unsigned NUM_PORT = 5,
    parameter bit          DEFLECT  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [NUM_PORT-1:0] req,
    input  logic [NUM_PORT-1:0] avail,
    output logic                out_valid,
    output logic [NUM_PORT-1:0] alloc,
    output logic [NUM_PORT-1:0] remain
);

    logic [NUM_PORT-1:0] prod;
    logic [NUM_PORT-1:0] cand;
    logic [NUM_PORT-1:0] grant;
    logic                found;

    logic                valid_q;
    logic [NUM_PORT-1:0] alloc_q, alloc_d;
    logic [NUM_PORT-1:0] remain_q, remain_d;

    // Candidate set: productive ports first, otherwise any free port when deflecting.
    always_comb begin
        prod = req & avail;
        cand = '0;
        if (prod != '0) begin
            cand = prod;
        end else if (DEFLECT && (req != '0)) begin
            cand = avail;
        end
    end

    // Fixed-priority pick, port 0 highest.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NUM_PORT); i++) begin
            if (cand[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        alloc_d  = '0;
        remain_d = avail;
        if (in_valid) begin
            alloc_d  = grant;
            remain_d = avail & ~grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            alloc_q  <= '0;
            remain_q <= '0;
        end else begin
            valid_q  <= in_valid;
            alloc_q  <= alloc_d;
            remain_q <= remain_d;
        end
    end

    assign out_valid = valid_q;
    assign alloc     = alloc_q;
    assign remain    = remain_q;

endmodule

// File: tb/tb_port_alloc.sv
// Self-checking bench for port_alloc: directed vectors, random sweep and async reset,
// with a deflecting and a non-deflecting instance driven from the same inputs.
module tb_port_alloc;

    localparam int unsigned N = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] avail = '0;

    logic         v1, v0;
    logic [N-1:0] alloc1, remain1, alloc0, remain0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    port_alloc #(.NUM_PORT(N), .DEFLECT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .req(req), .avail(avail),
        .out_valid(v1), .alloc(alloc1), .remain(remain1)
    );

    port_alloc #(.NUM_PORT(N), .DEFLECT(1'b0)) dut_nd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .req(req), .avail(avail),
        .out_valid(v0), .alloc(alloc0), .remain(remain0)
    );

    // Lowest set bit isolated as x & -x; candidates follow the grant rules directly.
    function automatic logic [N-1:0] model_grant(logic [N-1:0] r, logic [N-1:0] a, bit defl);
        logic [N-1:0] p;
        logic [N-1:0] pick;
        p = r & a;
        if (p != '0)               pick = p;
        else if (defl && r != '0)  pick = a;
        else                       pick = '0;
        return pick & (~pick + 1'b1);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results of the previous edge.
    logic         m_valid;
    logic [N-1:0] m_avail, m_alloc1, m_remain1, m_alloc0, m_remain0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_avail   <= '0;
            m_alloc1  <= '0;
            m_remain1 <= '0;
            m_alloc0  <= '0;
            m_remain0 <= '0;
        end else begin
            m_valid   <= in_valid;
            m_avail   <= avail;
            m_alloc1  <= in_valid ? model_grant(req, avail, 1'b1) : '0;
            m_remain1 <= in_valid ? (avail & ~model_grant(req, avail, 1'b1)) : avail;
            m_alloc0  <= in_valid ? model_grant(req, avail, 1'b0) : '0;
            m_remain0 <= in_valid ? (avail & ~model_grant(req, avail, 1'b0)) : avail;
        end
    end

    always @(negedge clk) begin
        check("valid_d1", 32'(v1), 32'(m_valid));
        check("alloc_d1", 32'(alloc1), 32'(m_alloc1));
        check("remain_d1", 32'(remain1), 32'(m_remain1));
        check("valid_d0", 32'(v0), 32'(m_valid));
        check("alloc_d0", 32'(alloc0), 32'(m_alloc0));
        check("remain_d0", 32'(remain0), 32'(m_remain0));
        check("inv_onehot", 32'($countones(alloc1) <= 1), 32'd1);
        check("inv_subset", 32'(alloc1 & ~m_avail), 32'd0);
        check("inv_cover", 32'(alloc1 | remain1), 32'(m_avail));
        check("inv_disjoint", 32'(alloc1 & remain1), 32'd0);
    end

    task automatic apply(logic [N-1:0] r, logic [N-1:0] a,
                         logic [N-1:0] ea1, logic [N-1:0] er1,
                         logic [N-1:0] ea0, logic [N-1:0] er0);
        @(negedge clk);
        in_valid = 1'b1;
        req      = r;
        avail    = a;
        @(posedge clk);
        #1;
        check("lit_valid", 32'(v1), 32'd1);
        check("lit_alloc_d1", 32'(alloc1), 32'(ea1));
        check("lit_remain_d1", 32'(remain1), 32'(er1));
        check("lit_alloc_d0", 32'(alloc0), 32'(ea0));
        check("lit_remain_d0", 32'(remain0), 32'(er0));
    endtask

    initial begin
        #1;
        check("rst_valid", 32'(v1), 32'd0);
        check("rst_alloc", 32'(alloc1), 32'd0);
        check("rst_remain", 32'(remain1), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        apply(5'b00000, 5'b11111, 5'b00000, 5'b11111, 5'b00000, 5'b11111);
        apply(5'b10000, 5'b11111, 5'b10000, 5'b01111, 5'b10000, 5'b01111);
        apply(5'b10000, 5'b10111, 5'b10000, 5'b00111, 5'b10000, 5'b00111);
        apply(5'b01010, 5'b10111, 5'b00010, 5'b10101, 5'b00010, 5'b10101);
        apply(5'b01011, 5'b10111, 5'b00001, 5'b10110, 5'b00001, 5'b10110);
        apply(5'b01000, 5'b10111, 5'b00001, 5'b10110, 5'b00000, 5'b10111);
        apply(5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000);

        // Idle cycle: free ports pass through untouched.
        @(negedge clk);
        in_valid = 1'b0;
        req      = 5'b00100;
        avail    = 5'b01101;
        @(posedge clk);
        #1;
        check("idle_valid", 32'(v1), 32'd0);
        check("idle_alloc", 32'(alloc1), 32'd0);
        check("idle_remain", 32'(remain1), 32'b01101);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            req      = N'($urandom);
            avail    = N'($urandom);
        end

        // Asynchronous reset between edges while results are in flight.
        @(negedge clk);
        in_valid = 1'b1;
        req      = 5'b00100;
        avail    = 5'b11111;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(v1), 32'd0);
        check("arst_alloc", 32'(alloc1), 32'd0);
        check("arst_remain", 32'(remain1), 32'd0);
        @(negedge clk);
        req   = 5'b01010;
        avail = 5'b10111;
        #2;
        rst_n = 1'b1;
        #1;
        check("rel_valid_pre", 32'(v1), 32'd0);
        @(posedge clk);
        #1;
        check("rel_valid", 32'(v1), 32'd1);
        check("rel_alloc", 32'(alloc1), 32'b00010);
        check("rel_remain", 32'(remain1), 32'b10101);

        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
